// File: rtl/xilinx_reset_sequencer.sv
// Board-level reset/boot sequencer: holds the Cheshire SoC in reset until the
// clock wizard lock is stable and (optionally) DDR has calibrated, latches the
// boot mode on release, handles VIO software resets and flags calib timeouts.
module xilinx_reset_sequencer #(
    parameter int unsigned LockStableCycles   = 1024,
    parameter int unsigned CalibTimeoutCycles = 2_500_000,
    parameter int unsigned SwResetCycles      = 16
) (
    input  logic       soc_clk,
    input  logic       rst_n,
    input  logic       clk_locked_i,
    input  logic       ddr_calib_done_i,
    input  logic       ddr_present_i,
    input  logic       sw_reset_i,
    input  logic [1:0] boot_mode_i,
    output logic       soc_rst_no,
    output logic [1:0] boot_mode_o,
    output logic       calib_timeout_o,
    output logic [2:0] state_o
);

    localparam int unsigned MaxLockCalib = (LockStableCycles > CalibTimeoutCycles) ?
                                           LockStableCycles : CalibTimeoutCycles;
    localparam int unsigned MaxCycles    = (MaxLockCalib > SwResetCycles) ?
                                           MaxLockCalib : SwResetCycles;
    localparam int unsigned CntW         = $clog2(MaxCycles) + 1;

    localparam logic [CntW-1:0] LockLast  = CntW'(LockStableCycles - 1);
    localparam logic [CntW-1:0] CalibLast = CntW'(CalibTimeoutCycles - 1);
    localparam logic [CntW-1:0] SwLast    = CntW'(SwResetCycles - 1);
    localparam logic [CntW-1:0] CntSat    = '1;

    typedef enum logic [2:0] {
        StWaitLock   = 3'd0,
        StLockStable = 3'd1,
        StWaitCalib  = 3'd2,
        StRelease    = 3'd3,
        StRun        = 3'd4,
        StSwRst      = 3'd5,
        StFault      = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              soc_rst_n_q, soc_rst_n_d;
    logic [1:0]        boot_mode_q, boot_mode_d;
    logic              calib_timeout_q, calib_timeout_d;
    logic              lock_meta_q, lock_meta_d;
    logic              lock_sync_q, lock_sync_d;
    logic              calib_meta_q, calib_meta_d;
    logic              calib_sync_q, calib_sync_d;
    logic              sw_prev_q, sw_prev_d;
    logic              swr;

    // Software reset acts only on the rising edge of the VIO request
    assign swr = sw_reset_i & ~sw_prev_q;

    // Next-state, counter, synchronizer and output computation
    always_comb begin
        state_d         = state_q;
        cnt_d           = (cnt_q == CntSat) ? cnt_q : cnt_q + CntW'(1);
        boot_mode_d     = boot_mode_q;
        calib_timeout_d = calib_timeout_q;
        lock_meta_d     = clk_locked_i;
        lock_sync_d     = lock_meta_q;
        calib_meta_d    = ddr_calib_done_i;
        calib_sync_d    = calib_meta_q;
        sw_prev_d       = sw_reset_i;

        case (state_q)
            StWaitLock: begin
                if (lock_sync_q) state_d = StLockStable;
            end
            StLockStable: begin
                if (!lock_sync_q)         state_d = StWaitLock;
                else if (cnt_q == LockLast) state_d = ddr_present_i ? StWaitCalib : StRelease;
            end
            StWaitCalib: begin
                if (!lock_sync_q)      state_d = StWaitLock;
                else if (calib_sync_q) state_d = StRelease;
                else if (cnt_q == CalibLast) begin
                    state_d         = StFault;
                    calib_timeout_d = 1'b1;
                end
            end
            StRelease: begin
                boot_mode_d = boot_mode_i;
                if (!lock_sync_q) state_d = StWaitLock;
                else if (swr)     state_d = StSwRst;
                else              state_d = StRun;
            end
            StRun: begin
                if (!lock_sync_q)                       state_d = StWaitLock;
                else if (swr)                           state_d = StSwRst;
                else if (ddr_present_i && !calib_sync_q) state_d = StWaitCalib;
            end
            StSwRst: begin
                // A fresh request while already resetting restarts the pulse
                if (!lock_sync_q)                        state_d = StWaitLock;
                else if (swr)                            cnt_d   = '0;
                else if (cnt_q >= SwLast && !sw_reset_i) state_d = StRelease;
            end
            StFault: begin
                // Only a software reset leaves FAULT; lock activity is ignored
                if (swr) begin
                    state_d         = StWaitLock;
                    calib_timeout_d = 1'b0;
                end
            end
            default: state_d = StWaitLock;
        endcase

        if (state_d != state_q) cnt_d = '0;
        soc_rst_n_d = (state_d == StRun);
    end

    // State, counter, synchronizer and output registers
    always_ff @(posedge soc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StWaitLock;
            cnt_q           <= '0;
            soc_rst_n_q     <= 1'b0;
            boot_mode_q     <= 2'b00;
            calib_timeout_q <= 1'b0;
            lock_meta_q     <= 1'b0;
            lock_sync_q     <= 1'b0;
            calib_meta_q    <= 1'b0;
            calib_sync_q    <= 1'b0;
            sw_prev_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            soc_rst_n_q     <= soc_rst_n_d;
            boot_mode_q     <= boot_mode_d;
            calib_timeout_q <= calib_timeout_d;
            lock_meta_q     <= lock_meta_d;
            lock_sync_q     <= lock_sync_d;
            calib_meta_q    <= calib_meta_d;
            calib_sync_q    <= calib_sync_d;
            sw_prev_q       <= sw_prev_d;
        end
    end

    assign soc_rst_no      = soc_rst_n_q;
    assign boot_mode_o     = boot_mode_q;
    assign calib_timeout_o = calib_timeout_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_xilinx_reset_sequencer.sv
// Directed bench for xilinx_reset_sequencer (LockStable=8, CalibTimeout=32, SwReset=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_xilinx_reset_sequencer;

    logic       soc_clk;
    logic       rst_n;
    logic       clk_locked_i;
    logic       ddr_calib_done_i;
    logic       ddr_present_i;
    logic       sw_reset_i;
    logic [1:0] boot_mode_i;
    logic       soc_rst_no;
    logic [1:0] boot_mode_o;
    logic       calib_timeout_o;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    xilinx_reset_sequencer #(
        .LockStableCycles  (8),
        .CalibTimeoutCycles(32),
        .SwResetCycles     (4)
    ) dut (
        .soc_clk         (soc_clk),
        .rst_n           (rst_n),
        .clk_locked_i    (clk_locked_i),
        .ddr_calib_done_i(ddr_calib_done_i),
        .ddr_present_i   (ddr_present_i),
        .sw_reset_i      (sw_reset_i),
        .boot_mode_i     (boot_mode_i),
        .soc_rst_no      (soc_rst_no),
        .boot_mode_o     (boot_mode_o),
        .calib_timeout_o (calib_timeout_o),
        .state_o         (state_o)
    );

    initial soc_clk = 1'b0;
    always #5 soc_clk = ~soc_clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge soc_clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst_n            = 1'b0;
        clk_locked_i     = 1'b0;
        ddr_calib_done_i = 1'b0;
        sw_reset_i       = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        boot_mode_i   = 2'b11;
        ddr_present_i = 1'b0;
        apply_reset();
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_o); end
        n_checks++; if (soc_rst_no !== 1'b0) begin n_fail++; $display("FAIL reset_soc_rst: got %0b expected 0", soc_rst_no); end
        n_checks++; if (boot_mode_o !== 2'b00) begin n_fail++; $display("FAIL reset_boot: got %0b expected 00", boot_mode_o); end
        n_checks++; if (calib_timeout_o !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %0b expected 0", calib_timeout_o); end
        tick(4);
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_nolock_state: got %0d expected 0", state_o); end
    endtask

    task automatic test_release_no_ddr();
        ddr_present_i = 1'b0;
        apply_reset();
        boot_mode_i  = 2'b10;
        clk_locked_i = 1'b1;
        tick(2);
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL nodr_sync_state: got %0d expected 0", state_o); end
        tick(1);
        n_checks++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL nodr_lockstable: got %0d expected 1", state_o); end
        tick(8);
        n_checks++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL nodr_release_state: got %0d expected 3", state_o); end
        n_checks++; if (soc_rst_no !== 1'b0) begin n_fail++; $display("FAIL nodr_early_release: got %0b expected 0", soc_rst_no); end
        tick(1);
        n_checks++; if (soc_rst_no !== 1'b1) begin n_fail++; $display("FAIL nodr_release_edge11: got %0b expected 1", soc_rst_no); end
        n_checks++; if (boot_mode_o !== 2'b10) begin n_fail++; $display("FAIL nodr_boot: got %0b expected 10", boot_mode_o); end
        n_checks++; if (state_o !== 3'd4) begin n_fail++; $display("FAIL nodr_run: got %0d expected 4", state_o); end
    endtask

    task automatic test_lock_glitch();
        ddr_present_i = 1'b0;
        apply_reset();
        clk_locked_i = 1'b1;
        tick(6);
        n_checks++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL glitch_pre_state: got %0d expected 1", state_o); end
        clk_locked_i = 1'b0;
        tick(3);
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL glitch_back_to_wait: got %0d expected 0", state_o); end
        clk_locked_i = 1'b1;
        tick(2);
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL glitch_still_wait: got %0d expected 0", state_o); end
        tick(1);
        n_checks++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL glitch_restable: got %0d expected 1", state_o); end
        tick(8);
        n_checks++; if (soc_rst_no !== 1'b0) begin n_fail++; $display("FAIL glitch_early_release: got %0b expected 0", soc_rst_no); end
        tick(1);
        n_checks++; if (soc_rst_no !== 1'b1) begin n_fail++; $display("FAIL glitch_release: got %0b expected 1", soc_rst_no); end
    endtask

    task automatic test_calib_timeout();
        ddr_present_i = 1'b1;
        apply_reset();
        clk_locked_i = 1'b1;
        tick(42);
        n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL tmo_wait_calib: got %0d expected 2", state_o); end
        n_checks++; if (calib_timeout_o !== 1'b0) begin n_fail++; $display("FAIL tmo_early_flag: got %0b expected 0", calib_timeout_o); end
        tick(1);
        n_checks++; if (state_o !== 3'd6) begin n_fail++; $display("FAIL tmo_fault_state: got %0d expected 6", state_o); end
        n_checks++; if (calib_timeout_o !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %0b expected 1", calib_timeout_o); end
        clk_locked_i = 1'b0;
        tick(4);
        n_checks++; if (state_o !== 3'd6) begin n_fail++; $display("FAIL tmo_lock_ignored: got %0d expected 6", state_o); end
        clk_locked_i = 1'b1;
        tick(3);
        sw_reset_i = 1'b1;
        tick(1);
        sw_reset_i = 1'b0;
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL tmo_swr_state: got %0d expected 0", state_o); end
        n_checks++; if (calib_timeout_o !== 1'b0) begin n_fail++; $display("FAIL tmo_swr_clear: got %0b expected 0", calib_timeout_o); end
    endtask

    task automatic test_ddr_release();
        ddr_present_i = 1'b1;
        apply_reset();
        boot_mode_i  = 2'b11;
        clk_locked_i = 1'b1;
        tick(12);
        n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL ddr_wait_calib: got %0d expected 2", state_o); end
        ddr_calib_done_i = 1'b1;
        tick(2);
        n_checks++; if (soc_rst_no !== 1'b0) begin n_fail++; $display("FAIL ddr_early_release: got %0b expected 0", soc_rst_no); end
        tick(1);
        n_checks++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL ddr_release_state: got %0d expected 3", state_o); end
        tick(1);
        n_checks++; if (soc_rst_no !== 1'b1) begin n_fail++; $display("FAIL ddr_release: got %0b expected 1", soc_rst_no); end
        n_checks++; if (boot_mode_o !== 2'b11) begin n_fail++; $display("FAIL ddr_boot: got %0b expected 11", boot_mode_o); end
        // The sampling edge counts as the first of the three edges to the fall
        ddr_calib_done_i = 1'b0;
        tick(2);
        n_checks++; if (soc_rst_no !== 1'b1) begin n_fail++; $display("FAIL ddr_drop_early: got %0b expected 1", soc_rst_no); end
        tick(1);
        n_checks++; if (soc_rst_no !== 1'b0) begin n_fail++; $display("FAIL ddr_drop_fall: got %0b expected 0", soc_rst_no); end
        n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL ddr_drop_state: got %0d expected 2", state_o); end
        ddr_calib_done_i = 1'b1;
        tick(3);
        n_checks++; if (soc_rst_no !== 1'b0) begin n_fail++; $display("FAIL ddr_recal_early: got %0b expected 0", soc_rst_no); end
        tick(1);
        n_checks++; if (soc_rst_no !== 1'b1) begin n_fail++; $display("FAIL ddr_recal_release: got %0b expected 1", soc_rst_no); end
    endtask

    task automatic test_sw_reset();
        boot_mode_i = 2'b01;
        sw_reset_i  = 1'b1;
        tick(1);
        sw_reset_i = 1'b0;
        n_checks++; if (state_o !== 3'd5) begin n_fail++; $display("FAIL swr_enter: got %0d expected 5", state_o); end
        n_checks++; if (soc_rst_no !== 1'b0) begin n_fail++; $display("FAIL swr_fall: got %0b expected 0", soc_rst_no); end
        tick(4);
        n_checks++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL swr_release_state: got %0d expected 3", state_o); end
        n_checks++; if (soc_rst_no !== 1'b0) begin n_fail++; $display("FAIL swr_pulse_short: got %0b expected 0", soc_rst_no); end
        n_checks++; if (boot_mode_o !== 2'b11) begin n_fail++; $display("FAIL swr_boot_hold: got %0b expected 11", boot_mode_o); end
        tick(1);
        n_checks++; if (soc_rst_no !== 1'b1) begin n_fail++; $display("FAIL swr_pulse_end: got %0b expected 1", soc_rst_no); end
        n_checks++; if (boot_mode_o !== 2'b01) begin n_fail++; $display("FAIL swr_boot_relatch: got %0b expected 01", boot_mode_o); end
        sw_reset_i = 1'b1;
        tick(20);
        n_checks++; if (state_o !== 3'd5) begin n_fail++; $display("FAIL swr_hold_state: got %0d expected 5", state_o); end
        n_checks++; if (soc_rst_no !== 1'b0) begin n_fail++; $display("FAIL swr_hold_low: got %0b expected 0", soc_rst_no); end
        sw_reset_i = 1'b0;
        tick(1);
        n_checks++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL swr_hold_release: got %0d expected 3", state_o); end
        tick(1);
        n_checks++; if (soc_rst_no !== 1'b1) begin n_fail++; $display("FAIL swr_hold_end: got %0b expected 1", soc_rst_no); end
    endtask

    task automatic test_lock_loss_run();
        clk_locked_i = 1'b0;
        tick(2);
        n_checks++; if (soc_rst_no !== 1'b1) begin n_fail++; $display("FAIL lockloss_early: got %0b expected 1", soc_rst_no); end
        tick(1);
        n_checks++; if (soc_rst_no !== 1'b0) begin n_fail++; $display("FAIL lockloss_fall: got %0b expected 0", soc_rst_no); end
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL lockloss_state: got %0d expected 0", state_o); end
    endtask

    task automatic test_async_reset();
        ddr_present_i = 1'b0;
        apply_reset();
        boot_mode_i  = 2'b10;
        clk_locked_i = 1'b1;
        tick(12);
        n_checks++; if (state_o !== 3'd4) begin n_fail++; $display("FAIL arst_run_setup: got %0d expected 4", state_o); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL arst_run_state: got %0d expected 0", state_o); end
        n_checks++; if (soc_rst_no !== 1'b0) begin n_fail++; $display("FAIL arst_run_soc: got %0b expected 0", soc_rst_no); end
        n_checks++; if (boot_mode_o !== 2'b00) begin n_fail++; $display("FAIL arst_run_boot: got %0b expected 00", boot_mode_o); end
        tick(1);
        rst_n = 1'b1;
        tick(2);
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL arst_restart_wait: got %0d expected 0", state_o); end
        tick(1);
        n_checks++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL arst_restart_stable: got %0d expected 1", state_o); end
        tick(9);
        n_checks++; if (state_o !== 3'd4) begin n_fail++; $display("FAIL arst_rerun: got %0d expected 4", state_o); end
        sw_reset_i = 1'b1;
        tick(2);
        n_checks++; if (state_o !== 3'd5) begin n_fail++; $display("FAIL arst_swrst_setup: got %0d expected 5", state_o); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL arst_swrst_state: got %0d expected 0", state_o); end
        n_checks++; if (boot_mode_o !== 2'b00) begin n_fail++; $display("FAIL arst_swrst_boot: got %0b expected 00", boot_mode_o); end
        n_checks++; if (calib_timeout_o !== 1'b0) begin n_fail++; $display("FAIL arst_swrst_timeout: got %0b expected 0", calib_timeout_o); end
        sw_reset_i = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(3);
        n_checks++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL arst_swrst_restart: got %0d expected 1", state_o); end
    endtask

    initial begin
        rst_n            = 1'b0;
        clk_locked_i     = 1'b0;
        ddr_calib_done_i = 1'b0;
        ddr_present_i    = 1'b0;
        sw_reset_i       = 1'b0;
        boot_mode_i      = 2'b00;
        test_reset();
        test_release_no_ddr();
        test_lock_glitch();
        test_calib_timeout();
        test_ddr_release();
        test_sw_reset();
        test_lock_loss_run();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
